// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signal bundle of the instruction cache.
// The slave modport is the cache. The master modport is the fetcher and memory controller.
interface icache_if;
  logic        rdy;
  logic        fetch_en;
  logic [31:0] pc_in;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_arrived;
  logic [31:0] mc_data;

  modport slave (
    input  rdy, fetch_en, pc_in, mc_arrived, mc_data,
    output instr_valid, instr_out, mc_req, mc_addr
  );

  modport master (
    output rdy, fetch_en, pc_in, mc_arrived, mc_data,
    input  instr_valid, instr_out, mc_req, mc_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache with one 32-bit word per line.
// Hits return in zero cycles. A miss blocks until the memory controller delivers the refill word.
//
// state | meaning
// IDLE  | looking up pc_in, hits served combinationally
// MISS  | refill outstanding for the latched mc_addr
module icache #(
  parameter int INDEX_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  icache_if.slave  bus
);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TW    = 30 - INDEX_WIDTH;

  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;

  state_t                  r_state, w_next;
  logic [LINES-1:0]        r_valid;
  logic [TW-1:0]           r_tag  [LINES];
  logic [31:0]             r_data [LINES];
  logic [31:0]             r_mc_addr;

  logic [INDEX_WIDTH-1:0]  w_index, w_fill_index;
  logic [TW-1:0]           w_tag, w_fill_tag;
  logic                    w_hit, w_miss_start, w_refill;
  logic                    w_unused;

  assign w_index      = bus.pc_in[INDEX_WIDTH+1:2];
  assign w_tag        = bus.pc_in[31:INDEX_WIDTH+2];
  assign w_fill_index = r_mc_addr[INDEX_WIDTH+1:2];
  assign w_fill_tag   = r_mc_addr[31:INDEX_WIDTH+2];
  assign w_unused     = &{1'b0, bus.pc_in[1:0]};

  assign w_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);

  assign bus.instr_valid = bus.rdy && bus.fetch_en && (r_state == IDLE) && w_hit;
  assign bus.instr_out   = r_data[w_index];
  // The request line is exactly "refill outstanding", so reset drops it at once.
  assign bus.mc_req      = (r_state == MISS);
  assign bus.mc_addr     = r_mc_addr;

  always_comb begin
    w_next       = r_state;
    w_miss_start = 1'b0;
    w_refill     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.rdy && bus.fetch_en && !w_hit) begin
          w_next       = MISS;
          w_miss_start = 1'b1;
        end
      end
      MISS: begin
        if (bus.rdy && bus.mc_arrived) begin
          w_next   = IDLE;
          w_refill = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_valid   <= '0;
      r_mc_addr <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss_start)
        r_mc_addr <= {bus.pc_in[31:2], 2'b00};
      if (w_refill)
        r_valid[w_fill_index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone guard them.
  always_ff @(posedge clk) begin
    if (w_refill) begin
      r_tag[w_fill_index]  <= w_fill_tag;
      r_data[w_fill_index] <= bus.mc_data;
    end
  end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hit, conflict eviction, pause, reset mid-miss,
// and ignored stray refills.
module tb_icache;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  icache_if bus ();

  icache #(.INDEX_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst            = 1'b0;
    bus.rdy        = 1'b1;
    bus.fetch_en   = 1'b0;
    bus.pc_in      = 32'h0;
    bus.mc_arrived = 1'b0;
    bus.mc_data    = 32'h0;
    #1;
    chk("reset_mc_req", {31'b0, bus.mc_req}, 32'h0);
    chk("reset_mc_addr", bus.mc_addr, 32'h0);
    bus.fetch_en = 1'b1;
    #1;
    chk("reset_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    #1;

    // Cold miss to 0x0
    chk("cold_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("cold_mc_req_same_cycle", {31'b0, bus.mc_req}, 32'h0);
    tick();
    chk("cold_mc_req", {31'b0, bus.mc_req}, 32'h1);
    chk("cold_mc_addr", bus.mc_addr, 32'h0);
    tick();
    tick();
    chk("cold_wait_mc_req", {31'b0, bus.mc_req}, 32'h1);
    bus.mc_arrived = 1'b1;
    bus.mc_data    = 32'h0000_0013;
    #1;
    chk("cold_arrive_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    tick();
    bus.mc_arrived = 1'b0;
    bus.mc_data    = 32'h0;
    #1;
    chk("cold_after_mc_req", {31'b0, bus.mc_req}, 32'h0);
    chk("cold_after_instr_valid", {31'b0, bus.instr_valid}, 32'h1);
    chk("cold_after_instr_out", bus.instr_out, 32'h0000_0013);

    // Hit with low address bits ignored
    bus.pc_in = 32'h2;
    #1;
    chk("hit_instr_valid", {31'b0, bus.instr_valid}, 32'h1);
    chk("hit_instr_out", bus.instr_out, 32'h0000_0013);
    tick();
    chk("hit_mc_req", {31'b0, bus.mc_req}, 32'h0);

    // Conflict miss at 0x400 (same index as 0x0)
    bus.pc_in = 32'h400;
    #1;
    chk("conflict_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    tick();
    chk("conflict_mc_req", {31'b0, bus.mc_req}, 32'h1);
    chk("conflict_mc_addr", bus.mc_addr, 32'h400);
    // pc_in moves to a resident address during the miss: no hit, refill target unchanged
    bus.pc_in = 32'h0;
    #1;
    chk("miss_pc_change_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    // Pause: arrival with rdy low must be ignored
    bus.rdy        = 1'b0;
    bus.mc_arrived = 1'b1;
    bus.mc_data    = 32'hDEAD_BEEF;
    #1;
    chk("pause_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    tick();
    bus.rdy        = 1'b1;
    bus.mc_arrived = 1'b0;
    #1;
    chk("pause_mc_req", {31'b0, bus.mc_req}, 32'h1);
    chk("pause_mc_addr", bus.mc_addr, 32'h400);
    chk("pause_no_write_old_line", {31'b0, bus.instr_valid}, 32'h0);
    bus.mc_arrived = 1'b1;
    tick();
    bus.mc_arrived = 1'b0;
    bus.mc_data    = 32'h0;
    // Back in IDLE with pc_in=0x0: line now holds 0x400, so 0x0 misses
    chk("evict_mc_req_idle", {31'b0, bus.mc_req}, 32'h0);
    chk("evict_old_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    bus.pc_in = 32'h400;
    #1;
    chk("conflict_hit_instr_valid", {31'b0, bus.instr_valid}, 32'h1);
    chk("conflict_hit_instr_out", bus.instr_out, 32'hDEAD_BEEF);
    bus.pc_in = 32'h0;
    tick();
    chk("evict_mc_req", {31'b0, bus.mc_req}, 32'h1);
    chk("evict_mc_addr", bus.mc_addr, 32'h0);
    bus.mc_arrived = 1'b1;
    bus.mc_data    = 32'h0000_0013;
    tick();
    bus.mc_arrived = 1'b0;
    chk("refill0_instr_out", bus.instr_out, 32'h0000_0013);
    chk("refill0_instr_valid", {31'b0, bus.instr_valid}, 32'h1);

    // Reset in the middle of a miss to 0x8
    bus.pc_in = 32'h8;
    tick();
    chk("rstmiss_mc_req", {31'b0, bus.mc_req}, 32'h1);
    chk("rstmiss_mc_addr", bus.mc_addr, 32'h8);
    rst = 1'b0;
    #1;
    chk("rstmiss_mc_req_async", {31'b0, bus.mc_req}, 32'h0);
    chk("rstmiss_mc_addr_async", bus.mc_addr, 32'h0);
    tick();
    rst = 1'b1;
    bus.fetch_en   = 1'b0;
    bus.mc_arrived = 1'b1;
    bus.mc_data    = 32'h5555_5555;
    tick();
    bus.mc_arrived = 1'b0;
    bus.mc_data    = 32'h0;
    #1;
    // fetch_en low on a miss address: no request, stay IDLE
    chk("noen_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    tick();
    chk("noen_mc_req", {31'b0, bus.mc_req}, 32'h0);
    bus.fetch_en = 1'b1;
    bus.pc_in    = 32'h0;
    #1;
    chk("post_rst_line0_miss", {31'b0, bus.instr_valid}, 32'h0);
    bus.pc_in = 32'h8;
    #1;
    chk("stray_no_write_miss", {31'b0, bus.instr_valid}, 32'h0);
    tick();
    chk("refetch_mc_req", {31'b0, bus.mc_req}, 32'h1);
    chk("refetch_mc_addr", bus.mc_addr, 32'h8);
    bus.mc_arrived = 1'b1;
    bus.mc_data    = 32'hCAFE_0008;
    tick();
    bus.mc_arrived = 1'b0;
    chk("refetch_instr_valid", {31'b0, bus.instr_valid}, 32'h1);
    chk("refetch_instr_out", bus.instr_out, 32'hCAFE_0008);
    chk("refetch_mc_req_clear", {31'b0, bus.mc_req}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 8, giving 2^INDEX_WIDTH direct-mapped lines of one 32-bit word each.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rdy  input  1  global pause; low freezes all state.
REQ-005 SHALL have port fetch_en  input  1  fetcher ready for an instruction.
REQ-006 SHALL have port pc_in  input  32  fetch address; bits [1:0] ignored.
REQ-007 SHALL have port instr_valid  output  1  instr_out valid for pc_in this cycle.
REQ-008 SHALL have port instr_out  output  32  fetched instruction word.
REQ-009 SHALL have port mc_req  output  1  refill request to memory controller.
REQ-010 SHALL have port mc_addr  output  32  word-aligned refill address.
REQ-011 SHALL have port mc_arrived  input  1  one-cycle pulse: refill data present.
REQ-012 SHALL have port mc_data  input  32  refill data, valid with mc_arrived.

Function
REQ-013 SHALL split pc_in as index = pc_in[INDEX_WIDTH+1:2], tag = pc_in[31:INDEX_WIDTH+2].
REQ-014 SHALL store per line: valid bit, tag (30-INDEX_WIDTH bits), 32-bit data.
REQ-015 SHALL implement FSM states IDLE and MISS.
REQ-016 SHALL define hit = valid[index] and tag-array[index] == tag.
REQ-017 SHALL drive instr_valid combinationally = rdy and fetch_en and state==IDLE and hit; zero-cycle hit latency.
REQ-018 SHALL drive instr_out = data-array[index] whenever instr_valid is 1; don't-care otherwise.
REQ-019 IDLE, rdy=1, fetch_en=1, miss: SHALL latch mc_addr = {pc_in[31:2],2'b00}, set mc_req=1 from the next cycle, go to MISS.
REQ-020 IDLE with fetch_en=0 or hit: SHALL stay in IDLE with mc_req=0.
REQ-021 MISS: SHALL hold mc_req=1 and mc_addr stable until the cycle mc_arrived is sampled high.
REQ-022 MISS with rdy=1 and mc_arrived=1: SHALL write mc_data, tag of mc_addr, valid=1 into line mc_addr[INDEX_WIDTH+1:2]; go to IDLE; mc_req=0 next cycle.
REQ-023 Miss-to-valid latency SHALL be memory latency + 1 cycle; on the cycle after the refill write the line hits via REQ-017 (no bypass of mc_data).
REQ-024 instr_valid SHALL be 0 in every cycle state==MISS, including the mc_arrived cycle.
REQ-025 pc_in changes during MISS: the refill SHALL complete to the latched mc_addr; the new pc_in is looked up only after return to IDLE.
REQ-026 Refill to an occupied line SHALL overwrite it (no replacement choice).
REQ-027 mc_arrived in IDLE SHALL be ignored, with no array write.
REQ-028 rdy=0: SHALL hold state, arrays, mc_req and mc_addr; instr_valid=0; mc_arrived ignored (controller frozen by same rdy).
REQ-029 Arrays SHALL be written only per REQ-022; no self-modifying-code coherence.

Reset
REQ-030 rst low SHALL asynchronously set state=IDLE, all valid bits=0, mc_req=0, mc_addr=0.
REQ-031 During reset instr_valid SHALL be 0; tag/data arrays are not reset.
REQ-032 rst asserted during MISS SHALL abandon the refill; an mc_arrived after reset release in IDLE is ignored per REQ-027.
REQ-033 After rst deassertion the first fetch of any address SHALL miss.

Verification
REQ-034 Cold miss: reset, fetch_en=1, pc_in=0x0 -> instr_valid=0, mc_req=1 next cycle, mc_addr=0x0; mc_arrived with mc_data=0x00000013 after 3 cycles -> mc_req=0 and instr_valid=1, instr_out=0x00000013 the following cycle.
REQ-035 Hit: after REQ-034, pc_in=0x2 -> instr_valid=1 same cycle, instr_out=0x00000013, mc_req stays 0.
REQ-036 Conflict: INDEX_WIDTH=8, fill 0x0, then fetch 0x400 -> miss, refill 0xDEADBEEF; then fetch 0x0 -> miss again (line evicted).
REQ-037 Pause: rdy=0 during MISS with mc_arrived=1 -> no write, state stays MISS, mc_req=1; rdy=1 with mc_arrived=1 -> refill completes.
REQ-038 Reset mid-miss: rst low while MISS -> mc_req=0 immediately; stray mc_arrived after release -> no write, fetch of same address misses.
REQ-039 fetch_en=0 with miss address on pc_in -> no mc_req, instr_valid=0, state IDLE.
